// File: rtl/popcount_sched_pkg.sv
// Shared constants and state encoding for the popcount scheduler.
`timescale 1ns/1ps
package popcount_sched_pkg;
    localparam int N_REQ_DEF   = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int RES_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 64;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t CLEAR = 2'd2;
endpackage

// File: rtl/popcount_scheduler_rr_arbiter.sv
// Rotating-priority one-hot select: first set request at or after ptr.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);
    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = PTR_W'(j);
            end
        end
    end
endmodule

// File: rtl/popcount_scheduler.sv
// Round-robin sharing of one bit_counter among N_REQ requesters,
// with start/done handshake and a watchdog abort.
`timescale 1ns/1ps
module popcount_scheduler
    import popcount_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RES_W   = RES_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [RES_W-1:0]        resp_result,
    output logic                    resp_err,
    output logic                    busy,
    output logic [DATA_W-1:0]       cnt_A,
    output logic                    cnt_start,
    input  logic                    cnt_done,
    input  logic [RES_W-1:0]        cnt_result
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [RES_W-1:0]  resp_result_q, resp_result_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] cnt_a_q, cnt_a_d;
    logic              cnt_start_q, cnt_start_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  idx_q, idx_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic [N_REQ-1:0]  arb_gnt;
    logic [PTR_W-1:0]  arb_idx;
    logic              arb_any;

    rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        resp_valid_d  = '0;
        resp_result_d = resp_result_q;
        resp_err_d    = resp_err_q;
        cnt_a_d       = cnt_a_q;
        cnt_start_d   = cnt_start_q;
        ptr_d         = ptr_q;
        idx_d         = idx_q;
        wd_d          = wd_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_gnt;
                    idx_d   = arb_idx;
                    cnt_a_d = req_data[arb_idx*DATA_W +: DATA_W];
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_start_d = 1'b1;
                if (cnt_done) begin
                    resp_valid_d  = grant_q;
                    resp_result_d = cnt_result;
                    resp_err_d    = 1'b0;
                    cnt_start_d   = 1'b0;
                    state_d       = CLEAR;
                end else if (wd_q == WD_W'(TIMEOUT)) begin
                    resp_valid_d  = grant_q;
                    resp_result_d = '0;
                    resp_err_d    = 1'b1;
                    cnt_start_d   = 1'b0;
                    state_d       = CLEAR;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            CLEAR: begin
                cnt_start_d = 1'b0;
                // Wait for the counter to return to idle before re-arming.
                if (!cnt_done) begin
                    ptr_d   = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + PTR_W'(1);
                    grant_d = '0;
                    wd_d    = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_err_q    <= 1'b0;
            cnt_a_q       <= '0;
            cnt_start_q   <= 1'b0;
            ptr_q         <= '0;
            idx_q         <= '0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_err_q    <= resp_err_d;
            cnt_a_q       <= cnt_a_d;
            cnt_start_q   <= cnt_start_d;
            ptr_q         <= ptr_d;
            idx_q         <= idx_d;
            wd_q          <= wd_d;
        end
    end

    assign grant       = grant_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_err    = resp_err_q;
    assign cnt_A       = cnt_a_q;
    assign cnt_start   = cnt_start_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_popcount_scheduler.sv
// Scoreboard bench for popcount_scheduler with a behavioural counter.
`timescale 1ns/1ps
module tb_popcount_scheduler;
    localparam int TO = 16;

    typedef struct {
        int       idx;
        logic [3:0] res;
        logic     err;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3:0]      req = '0;
    logic [3:0][7:0] rdata = '0;
    logic [3:0]      grant;
    logic [3:0]      resp_valid;
    logic [3:0]      resp_result;
    logic            resp_err;
    logic            busy;
    logic [7:0]      cnt_A;
    logic            cnt_start;
    logic            cnt_done;
    logic [3:0]      cnt_result;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    int   stub_mode = 0;
    int   c_st;
    int   c_cnt;
    int   k;

    always #5 clk = ~clk;

    popcount_scheduler #(
        .N_REQ(4), .DATA_W(8), .RES_W(4), .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (rdata),
        .grant       (grant),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .busy        (busy),
        .cnt_A       (cnt_A),
        .cnt_start   (cnt_start),
        .cnt_done    (cnt_done),
        .cnt_result  (cnt_result)
    );

    function automatic logic [3:0] pop8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = s + {3'b0, v[i]};
        return s;
    endfunction

    // Counter model: mode 0 normal, 1 never done, 2 done lingers after start falls.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            c_st <= 0; c_cnt <= 0;
            cnt_done <= 1'b0; cnt_result <= '0;
        end else begin
            case (c_st)
                0: if (cnt_start && stub_mode != 1) begin
                    c_st <= 1; c_cnt <= 3;
                end
                1: if (c_cnt == 0) begin
                    c_st <= 2; cnt_done <= 1'b1;
                    cnt_result <= pop8(cnt_A);
                end else c_cnt <= c_cnt - 1;
                2: if (!cnt_start) begin
                    if (stub_mode == 2) begin
                        c_st <= 3; c_cnt <= 2;
                    end else begin
                        c_st <= 0; cnt_done <= 1'b0;
                    end
                end
                3: if (c_cnt == 0) begin
                    c_st <= 0; cnt_done <= 1'b0;
                end else c_cnt <= c_cnt - 1;
                default: c_st <= 0;
            endcase
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int idx, input logic [3:0] res, input logic err);
        exp_t e;
        e.idx = idx; e.res = res; e.err = err;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset && resp_valid != 4'b0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected got=%b want=none", resp_valid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_valid", 32'(resp_valid), 32'(4'b1 << e.idx));
                check("resp_result", 32'(resp_result), 32'(e.res));
                check("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input logic v, input string nm);
        int n;
        n = 0;
        while (busy !== v && n < 300) begin
            tick();
            n++;
        end
        check(nm, 32'(busy), 32'(v));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_grant", 32'(grant), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_result", 32'(resp_result), 0);
        check("rst_resp_err", 32'(resp_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt_start", 32'(cnt_start), 0);
        check("rst_cnt_A", 32'(cnt_A), 0);

        // single request, dropped after grant
        rdata[0] = 8'hB5;
        req = 4'b0001;
        push(0, 4'd5, 1'b0);
        tick();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_cnt_A", 32'(cnt_A), 32'hB5);
        check("t1_busy", 32'(busy), 1);
        check("t1_start_lag", 32'(cnt_start), 0);
        tick();
        check("t1_start", 32'(cnt_start), 1);
        req = 4'b0000;
        wait_busy(1'b0, "t1_idle");
        check("t1_cnt_A_hold", 32'(cnt_A), 32'hB5);

        // all four requesting
        do_reset();
        rdata = {8'h81, 8'h0F, 8'h00, 8'hFF};
        push(0, 4'd8, 1'b0);
        push(1, 4'd0, 1'b0);
        push(2, 4'd4, 1'b0);
        push(3, 4'd2, 1'b0);
        req = 4'b1111;
        k = 0;
        while (resp_valid[3] !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        check("t2_last_resp", 32'(resp_valid[3]), 1);
        req = 4'b0001;
        push(0, 4'd8, 1'b0);
        wait_busy(1'b0, "t2_idle");
        wait_busy(1'b1, "t2_regrant");
        check("t2_grant0", 32'(grant), 32'h1);
        req = 4'b0000;
        wait_busy(1'b0, "t2_done");

        // request from 2 while 1 is running
        do_reset();
        rdata[1] = 8'h03;
        rdata[2] = 8'h07;
        req = 4'b0010;
        push(1, 4'd2, 1'b0);
        push(2, 4'd3, 1'b0);
        tick();
        check("t3_grant1", 32'(grant), 32'h2);
        req = 4'b0100;
        wait_busy(1'b0, "t3_idle");
        wait_busy(1'b1, "t3_next");
        check("t3_grant2", 32'(grant), 32'h4);
        check("t3_cnt_A", 32'(cnt_A), 32'h07);
        req = 4'b0000;
        wait_busy(1'b0, "t3_done");

        // watchdog abort, then normal service
        do_reset();
        stub_mode = 1;
        rdata[0] = 8'hFF;
        req = 4'b0001;
        push(0, 4'd0, 1'b1);
        tick();
        check("t4_grant", 32'(grant), 32'h1);
        req = 4'b0000;
        k = 0;
        while (resp_valid === 4'b0 && k < 200) begin
            tick();
            k++;
        end
        check("t4_latency", 32'(k), 32'(TO + 1));
        stub_mode = 0;
        rdata[1] = 8'h0F;
        req = 4'b0010;
        push(1, 4'd4, 1'b0);
        wait_busy(1'b0, "t4_idle");
        wait_busy(1'b1, "t4_next");
        check("t4_grant1", 32'(grant), 32'h2);
        req = 4'b0000;
        wait_busy(1'b0, "t4_done");

        // done lingers after start falls
        do_reset();
        stub_mode = 2;
        rdata[2] = 8'h81;
        req = 4'b0100;
        push(2, 4'd2, 1'b0);
        tick();
        req = 4'b0000;
        k = 0;
        while (resp_valid === 4'b0 && k < 200) begin
            tick();
            k++;
        end
        check("t5_resp", 32'(resp_valid), 32'h4);
        tick();
        k = 0;
        while (cnt_done === 1'b1 && k < 10) begin
            check("t5_hold_grant", 32'(grant), 32'h4);
            check("t5_hold_busy", 32'(busy), 1);
            check("t5_start_low", 32'(cnt_start), 0);
            tick();
            k++;
        end
        check("t5_linger", 32'(k >= 2), 1);
        wait_busy(1'b0, "t5_idle");
        check("t5_grant_clr", 32'(grant), 0);
        stub_mode = 0;

        // reset mid-run
        rdata[0] = 8'h01;
        req = 4'b1000;
        tick();
        tick();
        check("t6_start", 32'(cnt_start), 1);
        reset = 1'b1;
        #1;
        check("t6_start_rst", 32'(cnt_start), 0);
        check("t6_grant_rst", 32'(grant), 0);
        check("t6_busy_rst", 32'(busy), 0);
        tick();
        req = 4'b1111;
        tick();
        reset = 1'b0;
        push(0, 4'd1, 1'b0);
        tick();
        check("t6_ptr0", 32'(grant), 32'h1);
        req = 4'b0000;
        wait_busy(1'b0, "t6_done");
        tick();
        tick();
        check("sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
